// File: rtl/led_pkg.sv
// Shared constants for the LED sequencer / PWM dimmer path.
// Defaults assume the 12 MHz board clock used by the sequencer.
package led_pkg;

    localparam int                   LED_PWM_W         = 8;
    localparam logic [LED_PWM_W-1:0] LED_PWM_MAX       = 8'hFF;
    localparam int                   LED_PRESCALE_DEF  = 47;
    localparam int                   LED_FADE_STEP_DEF = 4;
    localparam int                   LED_NUM_CH        = 3;

    typedef logic [LED_PWM_W-1:0] led_level_t;

endpackage

// File: rtl/led_pwm_channel.sv
// One color channel: level register, linear fade toward the target and the
// PWM compare that drives the pin register.
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int FADE_STEP = LED_FADE_STEP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       boundary,
    input  led_level_t pwm_cnt,
    input  logic       en,
    input  led_level_t duty,
    input  logic       fade_en,
    output logic       pwm
);

    localparam logic [LED_PWM_W:0]   STEP9 = (LED_PWM_W + 1)'(FADE_STEP);
    localparam logic [LED_PWM_W-1:0] STEP8 = LED_PWM_W'(FADE_STEP);

    led_level_t         level_q, level_d;
    logic               pwm_q, pwm_d;
    logic [LED_PWM_W:0] target9, level9, diff_up, diff_dn;

    always_comb begin
        target9 = en ? {1'b0, duty} : '0;
        level9  = {1'b0, level_q};
        diff_up = target9 - level9;
        diff_dn = level9 - target9;
        level_d = level_q;
        if (boundary) begin
            if (!fade_en) begin
                level_d = target9[LED_PWM_W-1:0];
            end else if (target9 >= level9) begin
                level_d = (diff_up <= STEP9) ? target9[LED_PWM_W-1:0] : level_q + STEP8;
            end else begin
                level_d = (diff_dn <= STEP9) ? target9[LED_PWM_W-1:0] : level_q - STEP8;
            end
        end
        // pwm_cnt is the count of the next cycle, so the pin lines up with it
        pwm_d = (level_d == LED_PWM_MAX) | (pwm_cnt < level_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            level_q <= '0;
            pwm_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/led_pwm_dimmer.sv
// PWM dimmer behind the 3-color sequencer: shared prescaler and period
// counter, three per-color fade/compare channels.
module led_pwm_dimmer
    import led_pkg::*;
#(
    parameter int PRESCALE  = LED_PRESCALE_DEF,
    parameter int FADE_STEP = LED_FADE_STEP_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_r,
    input  logic       en_g,
    input  logic       en_b,
    input  led_level_t duty_r,
    input  led_level_t duty_g,
    input  led_level_t duty_b,
    input  logic       fade_en,
    output logic       pwm_r,
    output logic       pwm_g,
    output logic       pwm_b,
    output logic       period_start
);

    localparam int            PW       = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE);

    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    led_level_t    pwm_cnt_q, pwm_cnt_d;
    logic          tick, boundary;
    logic          period_start_q;

    logic       [LED_NUM_CH-1:0] en_v, pwm_v;
    led_level_t [LED_NUM_CH-1:0] duty_v;

    always_comb begin
        tick      = (pre_cnt_q == PRE_LAST);
        boundary  = tick & (pwm_cnt_q == LED_PWM_MAX);
        pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
        pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_cnt_q      <= '0;
            pwm_cnt_q      <= '0;
            period_start_q <= 1'b0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            period_start_q <= boundary;
        end
    end

    assign en_v   = {en_b, en_g, en_r};
    assign duty_v = {duty_b, duty_g, duty_r};

    for (genvar c = 0; c < LED_NUM_CH; c++) begin : g_ch
        led_pwm_channel #(.FADE_STEP(FADE_STEP)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .boundary (boundary),
            .pwm_cnt  (pwm_cnt_d),
            .en       (en_v[c]),
            .duty     (duty_v[c]),
            .fade_en  (fade_en),
            .pwm      (pwm_v[c])
        );
    end

    assign pwm_r        = pwm_v[0];
    assign pwm_g        = pwm_v[1];
    assign pwm_b        = pwm_v[2];
    assign period_start = period_start_q;

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Bench for led_pwm_dimmer with PRESCALE = 0 (one PWM period = 256 clk).
// Expected per-period high counts are queued at stimulus time and popped as periods are measured.
module tb_led_pwm_dimmer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en_r = 1'b0, en_g = 1'b0, en_b = 1'b0;
    logic [7:0] duty_r = '0, duty_g = '0, duty_b = '0;
    logic       fade_en = 1'b0;
    logic       pwm_r, pwm_g, pwm_b, period_start;

    int errors = 0;
    int checks = 0;

    typedef struct {int r; int g; int b;} exp_t;
    exp_t sb_q[$];

    typedef struct {logic en; logic [7:0] duty; int exp_hi;} vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    led_pwm_dimmer #(.PRESCALE(0), .FADE_STEP(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .en_r         (en_r),
        .en_g         (en_g),
        .en_b         (en_b),
        .duty_r       (duty_r),
        .duty_g       (duty_g),
        .duty_b       (duty_b),
        .fade_en      (fade_en),
        .pwm_r        (pwm_r),
        .pwm_g        (pwm_g),
        .pwm_b        (pwm_b),
        .period_start (period_start)
    );

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic wait_ps(input string nm);
        bit found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (period_start) found = 1'b1;
        end
        check({nm, ".period_start_seen"}, int'(found), 1);
    endtask

    // Counts 256 samples starting at the current negedge; mid selects an in-period action.
    task automatic count_period(input int mid, output int hr, output int hg, output int hb,
                                output int first_r);
        hr = 0; hg = 0; hb = 0; first_r = 0;
        for (int i = 0; i < 256; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 0) first_r = int'(pwm_r);
            hr += int'(pwm_r);
            hg += int'(pwm_g);
            hb += int'(pwm_b);
            if (mid == 1) begin
                if (i == 50) duty_g = 8'd200;
                if (i == 60) duty_g = 8'd10;
                if (i == 70) en_g = 1'b0;
            end
            if (mid == 2 && i == 100) fade_en = 1'b0;
        end
    endtask

    task automatic score(input string nm, input int hr, input int hg, input int hb);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got r=%0d g=%0d b=%0d", nm, hr, hg, hb);
        end else begin
            e = sb_q.pop_front();
            check({nm, ".r_high"}, hr, e.r);
            check({nm, ".g_high"}, hg, e.g);
            check({nm, ".b_high"}, hb, e.b);
        end
    endtask

    task automatic measure(input string nm, input int mid, output int first_r);
        int hr, hg, hb;
        wait_ps(nm);
        count_period(mid, hr, hg, hb, first_r);
        score(nm, hr, hg, hb);
    endtask

    // Current negedge is cycle 0 after reset release.
    task automatic post_reset(input string nm);
        int bad = 0;
        for (int k = 0; k < 256; k++) begin
            if (k > 0) @(negedge clk);
            if (pwm_r || pwm_g || pwm_b || period_start) bad++;
        end
        check({nm, ".quiet_until_boundary"}, bad, 0);
        @(negedge clk);
        check({nm, ".period_start_at_256"}, int'(period_start), 1);
    endtask

    initial begin
        int fr, hr, hg, hb, bad;

        vecs[0] = '{1'b1, 8'd64,  64};
        vecs[1] = '{1'b1, 8'd0,   0};
        vecs[2] = '{1'b1, 8'd255, 256};
        vecs[3] = '{1'b1, 8'd1,   1};
        vecs[4] = '{1'b1, 8'd128, 128};
        vecs[5] = '{1'b0, 8'd200, 0};

        // Reset held with everything enabled
        en_r = 1'b1; en_g = 1'b1; en_b = 1'b1;
        duty_r = 8'd128; duty_g = 8'd128; duty_b = 8'd128;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (pwm_r || pwm_g || pwm_b || period_start) bad++;
        end
        check("reset.outputs_low", bad, 0);
        rst = 1'b1;
        sb_q.push_back('{128, 128, 128});
        post_reset("reset");
        count_period(0, hr, hg, hb, fr);
        score("reset.first_period", hr, hg, hb);

        // Static duty table on red, fade disabled
        en_g = 1'b0; en_b = 1'b0;
        foreach (vecs[i]) begin
            en_r   = vecs[i].en;
            duty_r = vecs[i].duty;
            sb_q.push_back('{vecs[i].exp_hi, 0, 0});
            measure($sformatf("static%0d", i), 0, fr);
            check($sformatf("static%0d.first_cycle", i), fr, (vecs[i].exp_hi > 0) ? 1 : 0);
        end

        // Fade-in on green, enable raised mid-period
        fade_en = 1'b1; duty_g = 8'd10;
        wait_ps("fadein.sync");
        repeat (100) @(negedge clk);
        en_g = 1'b1;
        sb_q.push_back('{0, 4, 0});
        sb_q.push_back('{0, 8, 0});
        sb_q.push_back('{0, 10, 0});
        for (int p = 0; p < 3; p++) measure($sformatf("fadein%0d", p), 0, fr);

        // Fade-out with a mid-period duty glitch that must not show up
        sb_q.push_back('{0, 10, 0});
        sb_q.push_back('{0, 6, 0});
        sb_q.push_back('{0, 2, 0});
        sb_q.push_back('{0, 0, 0});
        measure("fadeout0", 1, fr);
        for (int p = 1; p < 4; p++) measure($sformatf("fadeout%0d", p), 0, fr);

        // Fade abort on blue: fade_en dropped during the level-12 period
        en_b = 1'b1; duty_b = 8'd255;
        sb_q.push_back('{0, 0, 4});
        sb_q.push_back('{0, 0, 8});
        sb_q.push_back('{0, 0, 12});
        sb_q.push_back('{0, 0, 256});
        measure("abort0", 0, fr);
        measure("abort1", 0, fr);
        measure("abort2", 2, fr);
        measure("abort3", 0, fr);

        // Reset in the middle of a fade starting from level 100
        duty_b = 8'd100;
        wait_ps("midrst.sync");
        fade_en = 1'b1; duty_b = 8'd200;
        repeat (50) @(negedge clk);
        check("midrst.pwm_b_before", int'(pwm_b), 1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst.outputs_low", int'(pwm_r | pwm_g | pwm_b | period_start), 0);
        rst = 1'b1;
        sb_q.push_back('{0, 0, 4});
        post_reset("midrst");
        count_period(0, hr, hg, hb, fr);
        score("midrst.first_period", hr, hg, hb);

        check("scoreboard.drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
